// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - day-seconds constant, channel state encoding and modulo-day add for alarm_bank
package alarm_pkg;

   localparam int DAY_SECONDS = 86400;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZED = 2'd2
   } alarm_state_t;

   // Operands are below DAY_SECONDS, so a single conditional subtract brings the sum back into range.
   function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] sum;
      sum = a + b;
      return (sum >= 32'(DAY_SECONDS)) ? sum - 32'(DAY_SECONDS) : sum;
   endfunction

endpackage

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: config registers plus IDLE/RINGING/SNOOZED FSM
// Snooze state and registers exist only when ALARM_SNOOZE_EN is defined.
module alarm_channel
   import alarm_pkg::*;
#(
   parameter int TIME_W     = 17,
   parameter int LEN_W      = 6,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic              sec_clk,
   input  logic              rst,
   input  logic [TIME_W-1:0] cur_sec,
   input  logic              new_sec,
   input  logic              off,
   input  logic              snooze_edge,
   input  logic              cfg_wr,
   input  logic [TIME_W-1:0] cfg_tar_sec,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              cfg_en,
   output logic              ring_next,
   output logic              pend_next
);

   alarm_state_t      state, state_n;
   logic [TIME_W-1:0] tar;
   logic [LEN_W-1:0]  len, cnt, cnt_n;
   logic              en;
   logic              hit;

   assign hit = en && (len != '0) && new_sec && (cur_sec == tar);

`ifdef ALARM_SNOOZE_EN
   localparam int SNZ_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
   logic [SNZ_W-1:0]  snz_cnt, snz_cnt_n;
   logic [TIME_W-1:0] snz_tar, snz_tar_n;
`else
   localparam int unused_snz_cfg = SNOOZE_SEC + MAX_SNOOZE;
   logic unused_snz;
   assign unused_snz = snooze_edge;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_n = snz_cnt;
      snz_tar_n = snz_tar;
`endif
      if (cfg_wr || off) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hit) begin
                  state_n = ST_RINGING;
                  cnt_n   = len;
`ifdef ALARM_SNOOZE_EN
                  snz_cnt_n = '0;
`endif
               end
            end
            ST_RINGING: begin
`ifdef ALARM_SNOOZE_EN
               if (snooze_edge && (snz_cnt < SNZ_W'(MAX_SNOOZE))) begin
                  state_n   = ST_SNOOZED;
                  snz_tar_n = TIME_W'(wrap_add(32'(cur_sec), 32'(SNOOZE_SEC)));
               end else
`endif
               if (cnt == LEN_W'(1)) state_n = ST_IDLE;
               else                  cnt_n   = cnt - LEN_W'(1);
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZED: begin
               if (new_sec && (cur_sec == snz_tar)) begin
                  state_n   = ST_RINGING;
                  cnt_n     = len;
                  snz_cnt_n = snz_cnt + SNZ_W'(1);
               end
            end
`endif
            default: state_n = ST_IDLE;
         endcase
      end
   end

   assign ring_next = (state_n == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
   assign pend_next = (state_n == ST_SNOOZED);
`else
   assign pend_next = 1'b0;
`endif

   always_ff @(posedge sec_clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         tar   <= '0;
         len   <= '0;
         en    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt <= '0;
         snz_tar <= '0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (cfg_wr) begin
            tar <= cfg_tar_sec;
            len <= cfg_len;
            en  <= cfg_en;
         end
`ifdef ALARM_SNOOZE_EN
         snz_cnt <= snz_cnt_n;
         snz_tar <= snz_tar_n;
`endif
      end
   end

endmodule

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - N_CH alarm channels with shared second-change detect, cfg decode and ring priority
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_bank
   import alarm_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int TIME_W     = 17,
   parameter int LEN_W      = 6,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic                                      sec_clk,
   input  logic                                      rst,
   input  logic [TIME_W-1:0]                         cur_sec,
   input  logic                                      cfg_we,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
   input  logic [TIME_W-1:0]                         cfg_tar_sec,
   input  logic [LEN_W-1:0]                          cfg_len,
   input  logic                                      cfg_en,
   input  logic                                      off,
   input  logic                                      snooze,
   output logic                                      alarming,
   output logic [N_CH-1:0]                           ring_vec,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ring_id,
   output logic [N_CH-1:0]                           snooze_pend,
   output logic                                      cfg_err
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [TIME_W-1:0] prev_sec;
   logic              snooze_prev;
   logic              new_sec, snooze_edge, cfg_ok;
   logic [N_CH-1:0]   ring_next, pend_next;
   logic [CH_W-1:0]   id_next;

   assign new_sec     = (cur_sec != prev_sec);
   assign snooze_edge = snooze && !snooze_prev;
   assign cfg_ok      = (32'(cfg_tar_sec) < 32'(DAY_SECONDS)) && (32'(cfg_ch) < 32'(N_CH));

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      alarm_channel #(
         .TIME_W     (TIME_W),
         .LEN_W      (LEN_W),
         .SNOOZE_SEC (SNOOZE_SEC),
         .MAX_SNOOZE (MAX_SNOOZE)
      ) u_ch (
         .sec_clk     (sec_clk),
         .rst         (rst),
         .cur_sec     (cur_sec),
         .new_sec     (new_sec),
         .off         (off),
         .snooze_edge (snooze_edge),
         .cfg_wr      (cfg_we && cfg_ok && (32'(cfg_ch) == i)),
         .cfg_tar_sec (cfg_tar_sec),
         .cfg_len     (cfg_len),
         .cfg_en      (cfg_en),
         .ring_next   (ring_next[i]),
         .pend_next   (pend_next[i])
      );
   end

   // Scan from the top so the lowest ringing index wins.
   always_comb begin
      id_next = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (ring_next[i]) id_next = CH_W'(i);
      end
   end

   always_ff @(posedge sec_clk or posedge rst) begin
      if (rst) begin
         prev_sec    <= TIME_W'(DAY_SECONDS);
         snooze_prev <= 1'b0;
         ring_vec    <= '0;
         snooze_pend <= '0;
         alarming    <= 1'b0;
         ring_id     <= '0;
         cfg_err     <= 1'b0;
      end else begin
         prev_sec    <= cur_sec;
         snooze_prev <= snooze;
         ring_vec    <= ring_next;
         snooze_pend <= pend_next;
         alarming    <= |ring_next;
         ring_id     <= id_next;
         cfg_err     <= cfg_we && !cfg_ok;
      end
   end

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - scoreboard bench for alarm_bank; snooze vectors run when ALARM_SNOOZE_EN is defined
module tb_alarm_bank;

   typedef struct packed {
      logic [3:0] ring;
      logic [3:0] pend;
      logic       err;
   } exp_t;

   logic        sec_clk = 1'b0;
   logic        rst;
   logic [16:0] cur_sec;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [16:0] cfg_tar_sec;
   logic [5:0]  cfg_len;
   logic        cfg_en;
   logic        off;
   logic        snooze;
   logic        alarming;
   logic [3:0]  ring_vec;
   logic [1:0]  ring_id;
   logic [3:0]  snooze_pend;
   logic        cfg_err;

   exp_t  exp_q[$];
   exp_t  mon_e;
   int    n_checks = 0;
   int    n_fails  = 0;
   string tag      = "init";

   alarm_bank #(.N_CH(4), .TIME_W(17), .LEN_W(6), .SNOOZE_SEC(5), .MAX_SNOOZE(3)) dut (
      .sec_clk     (sec_clk),
      .rst         (rst),
      .cur_sec     (cur_sec),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_tar_sec (cfg_tar_sec),
      .cfg_len     (cfg_len),
      .cfg_en      (cfg_en),
      .off         (off),
      .snooze      (snooze),
      .alarming    (alarming),
      .ring_vec    (ring_vec),
      .ring_id     (ring_id),
      .snooze_pend (snooze_pend),
      .cfg_err     (cfg_err)
   );

   always #5 sec_clk = ~sec_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s/%s cur_sec=%0d: got %0h, expected %0h", tag, name, cur_sec, act, req);
      end
   endtask

   function automatic logic [1:0] low_id(input logic [3:0] v);
      logic [1:0] id;
      id = 2'd0;
      for (int i = 3; i >= 0; i--) if (v[i]) id = 2'(i);
      return id;
   endfunction

   always @(negedge sec_clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("ring_vec", 32'(ring_vec), 32'(mon_e.ring));
         check("alarming", 32'(alarming), 32'(|mon_e.ring));
         check("ring_id", 32'(ring_id), 32'(low_id(mon_e.ring)));
         check("snooze_pend", 32'(snooze_pend), 32'(mon_e.pend));
         check("cfg_err", 32'(cfg_err), 32'(mon_e.err));
      end
   end

   task automatic set_cfg(input int ch, input int tar, input int len, input logic en);
      cfg_we      = 1'b1;
      cfg_ch      = 2'(ch);
      cfg_tar_sec = 17'(tar);
      cfg_len     = 6'(len);
      cfg_en      = en;
   endtask

   task automatic step(input int cur, input logic o, input logic s,
                       input logic [3:0] er, input logic [3:0] ep, input logic ee);
      @(negedge sec_clk);
      cur_sec = 17'(cur);
      off     = o;
      snooze  = s;
      @(posedge sec_clk);
      #1;
      cfg_we = 1'b0;
      exp_q.push_back('{ring: er, pend: ep, err: ee});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cur_sec = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_tar_sec = '0;
      cfg_len = '0; cfg_en = 1'b0; off = 1'b0; snooze = 1'b0;

      tag = "reset";
      step(0, 0, 0, 4'b0000, 4'b0000, 0);
      step(0, 0, 0, 4'b0000, 4'b0000, 0);
      rst = 1'b0;

      tag = "basic";
      set_cfg(0, 10, 20, 1);
      step(0, 0, 0, 4'b0000, 4'b0000, 0);
      for (int t = 1; t <= 40; t++)
         step(t, 0, 0, (t >= 10 && t < 30) ? 4'b0001 : 4'b0000, 4'b0000, 0);

      tag = "off";
      step(5, 0, 0, 4'b0000, 4'b0000, 0);
      for (int t = 6; t <= 35; t++)
         step(t, (t == 15 || t == 30), 0, (t >= 10 && t < 15) ? 4'b0001 : 4'b0000, 4'b0000, 0);

      tag = "hold";
      step(9, 0, 0, 4'b0000, 4'b0000, 0);
      for (int k = 0; k <= 25; k++)
         step(10, 0, 0, (k < 20) ? 4'b0001 : 4'b0000, 4'b0000, 0);

`ifdef ALARM_SNOOZE_EN
      tag = "snooze";
      set_cfg(0, 10, 20, 1);
      for (int t = 8; t <= 50; t++) begin
         logic s, r, p;
         s = (t == 12 || t == 19 || t == 25 || t == 31);
         r = (t >= 10 && t < 12) || (t >= 17 && t < 19) || (t == 24) || (t >= 30 && t < 50);
         p = (t >= 12 && t < 17) || (t >= 19 && t < 24) || (t >= 25 && t < 30);
         step(t, 0, s, {3'b000, r}, {3'b000, p}, 0);
      end
`endif

      tag = "wrap";
      set_cfg(0, 10, 20, 0);
      step(86390, 0, 0, 4'b0000, 4'b0000, 0);
      set_cfg(1, 86398, 5, 1);
      step(86396, 0, 0, 4'b0000, 4'b0000, 0);
      for (int k = 0; k <= 7; k++)
         step((86397 + k) % 86400, 0, 0, (k >= 1 && k <= 5) ? 4'b0010 : 4'b0000, 4'b0000, 0);

`ifdef ALARM_SNOOZE_EN
      tag = "wrap_snooze";
      set_cfg(1, 86398, 5, 1);
      step(86396, 0, 0, 4'b0000, 4'b0000, 0);
      for (int k = 0; k <= 13; k++)
         step((86397 + k) % 86400, 0, (k == 2),
              (k == 1 || (k >= 7 && k <= 11)) ? 4'b0010 : 4'b0000,
              (k >= 2 && k <= 6) ? 4'b0010 : 4'b0000, 0);
`endif

      tag = "multi";
      set_cfg(1, 86398, 5, 0);
      step(45, 0, 0, 4'b0000, 4'b0000, 0);
      set_cfg(2, 50, 10, 1);
      step(46, 0, 0, 4'b0000, 4'b0000, 0);
      set_cfg(3, 50, 10, 1);
      step(47, 0, 0, 4'b0000, 4'b0000, 0);
      for (int t = 48; t <= 60; t++) begin
         if (t == 52) set_cfg(2, 50, 10, 1);
         step(t, 0, 0, (t < 50) ? 4'b0000 : (t < 52) ? 4'b1100 : (t < 60) ? 4'b1000 : 4'b0000,
              4'b0000, 0);
      end
      step(49, 0, 0, 4'b0000, 4'b0000, 0);
      step(50, 0, 0, 4'b1100, 4'b0000, 0);
      step(51, 1, 0, 4'b0000, 4'b0000, 0);

      tag = "cfg_err";
      set_cfg(3, 86400, 7, 0);
      step(48, 0, 0, 4'b0000, 4'b0000, 1);
      step(49, 0, 0, 4'b0000, 4'b0000, 0);
      step(50, 0, 0, 4'b1100, 4'b0000, 0);
      step(51, 0, 0, 4'b1100, 4'b0000, 0);

      tag = "async_rst";
      @(negedge sec_clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_ring_vec", 32'(ring_vec), 32'd0);
      check("rst_alarming", 32'(alarming), 32'd0);
      check("rst_ring_id", 32'(ring_id), 32'd0);
      step(52, 0, 0, 4'b0000, 4'b0000, 0);
      rst = 1'b0;
      step(50, 0, 0, 4'b0000, 4'b0000, 0);
      step(51, 0, 0, 4'b0000, 4'b0000, 0);

      repeat (3) @(negedge sec_clk);
      tag = "end";
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
